// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - MIPS write-back stage with 32-entry GPR file, WB->ID bypass and write counter
//
// Purpose:
//   Selects the write-back value from the MEM/WB pipeline register, commits it
//   to the GPR array and serves two ID-stage read ports. These ports can bypass
//   the value being written in the same cycle. A debug read port shows committed
//   state only. A saturating counter tracks the number of committed writes.
//
// Ports:
//   clk          in   1       clock, all state on posedge
//   rst          in   1       synchronous reset, active-high
//   readData_WB  in   DATA_W  load data from MEM/WB
//   aluRes_WB    in   DATA_W  ALU result from MEM/WB
//   writeReg_WB  in   ADDR_W  destination register index
//   regWrite_WB  in   1       write enable
//   memToReg_WB  in   1       1 = write readData_WB, 0 = write aluRes_WB
//   rs_addr      in   ADDR_W  read port A index
//   rt_addr      in   ADDR_W  read port B index
//   dbg_addr     in   ADDR_W  debug read index
//   rs_data      out  DATA_W  read port A data (combinational)
//   rt_data      out  DATA_W  read port B data (combinational)
//   dbg_data     out  DATA_W  debug read data (combinational, never bypassed)
//   wbData       out  DATA_W  selected write-back value
//   wr_count     out  CNT_W   committed GPR writes, saturating

module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] readData_WB,
    input  logic [DATA_W-1:0] aluRes_WB,
    input  logic [ADDR_W-1:0] writeReg_WB,
    input  logic              regWrite_WB,
    input  logic              memToReg_WB,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] dbg_data,
    output logic [DATA_W-1:0] wbData,
    output logic [CNT_W-1:0]  wr_count
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] gpr [DEPTH];
    logic              commit;

    assign wbData = memToReg_WB ? readData_WB : aluRes_WB;

    // Writes to r0 are dropped. Because commit is also gated by rst, a write
    // issued in the reset cycle is lost, and the bypass stays inactive.
    assign commit = regWrite_WB & (writeReg_WB != '0) & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                gpr[i] <= '0;
            end
            wr_count <= '0;
        end else begin
            if (commit) begin
                gpr[writeReg_WB] <= wbData;
                if (wr_count != {CNT_W{1'b1}}) begin
                    wr_count <= wr_count + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    // r0 is forced to zero after the bypass mux. This means a bypass can never leak
    // a value into index 0.
    always_comb begin
        rs_data = gpr[rs_addr];
        if (BYPASS && commit && (writeReg_WB == rs_addr)) begin
            rs_data = wbData;
        end
        if (rs_addr == '0) begin
            rs_data = '0;
        end
    end

    always_comb begin
        rt_data = gpr[rt_addr];
        if (BYPASS && commit && (writeReg_WB == rt_addr)) begin
            rt_data = wbData;
        end
        if (rt_addr == '0) begin
            rt_data = '0;
        end
    end

    always_comb begin
        dbg_data = gpr[dbg_addr];
        if (dbg_addr == '0) begin
            dbg_data = '0;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - scoreboard testbench for wb_regfile

module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] readData_WB;
    logic [31:0] aluRes_WB;
    logic [4:0]  writeReg_WB;
    logic        regWrite_WB;
    logic        memToReg_WB;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  dbg_addr;

    logic [31:0] rs_data, rt_data, dbg_data, wbData, wr_count;
    logic [31:0] s_rs, s_rt, s_dbg, s_wb;
    logic [2:0]  s_cnt;
    logic [31:0] n_rs, n_rt, n_dbg, n_wb, n_cnt;

    always #5 clk = ~clk;

    wb_regfile u_dut (
        .clk(clk), .rst(rst), .readData_WB(readData_WB), .aluRes_WB(aluRes_WB),
        .writeReg_WB(writeReg_WB), .regWrite_WB(regWrite_WB), .memToReg_WB(memToReg_WB),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .dbg_addr(dbg_addr),
        .rs_data(rs_data), .rt_data(rt_data), .dbg_data(dbg_data),
        .wbData(wbData), .wr_count(wr_count)
    );

    wb_regfile #(.CNT_W(3)) u_sat (
        .clk(clk), .rst(rst), .readData_WB(readData_WB), .aluRes_WB(aluRes_WB),
        .writeReg_WB(writeReg_WB), .regWrite_WB(regWrite_WB), .memToReg_WB(memToReg_WB),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .dbg_addr(dbg_addr),
        .rs_data(s_rs), .rt_data(s_rt), .dbg_data(s_dbg),
        .wbData(s_wb), .wr_count(s_cnt)
    );

    wb_regfile #(.BYPASS(1'b0)) u_nob (
        .clk(clk), .rst(rst), .readData_WB(readData_WB), .aluRes_WB(aluRes_WB),
        .writeReg_WB(writeReg_WB), .regWrite_WB(regWrite_WB), .memToReg_WB(memToReg_WB),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .dbg_addr(dbg_addr),
        .rs_data(n_rs), .rt_data(n_rt), .dbg_data(n_dbg),
        .wbData(n_wb), .wr_count(n_cnt)
    );

    localparam int SEL_RS    = 0;
    localparam int SEL_RT    = 1;
    localparam int SEL_DBG   = 2;
    localparam int SEL_WB    = 3;
    localparam int SEL_CNT   = 4;
    localparam int SEL_SCNT  = 5;
    localparam int SEL_NRS   = 6;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic expect_val(input string name, input int sel, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.exp  = exp;
        q.push_back(c);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are combinational, so every expectation queued
    // during a cycle is checked at the following negedge.
    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                chk_t        c;
                logic [31:0] act;
                c = q.pop_front();
                case (c.sel)
                    SEL_RS:   act = rs_data;
                    SEL_RT:   act = rt_data;
                    SEL_DBG:  act = dbg_data;
                    SEL_WB:   act = wbData;
                    SEL_CNT:  act = wr_count;
                    SEL_SCNT: act = {29'd0, s_cnt};
                    SEL_NRS:  act = n_rs;
                    default:  act = 'x;
                endcase
                n_tests++;
                if (act !== c.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        readData_WB = '0; aluRes_WB = '0; writeReg_WB = '0;
        regWrite_WB = 1'b0; memToReg_WB = 1'b0;
        rs_addr = '0; rt_addr = '0; dbg_addr = '0;
        step();
        step();
        rst = 1'b0;

        // 1: everything reads zero after reset
        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i); rt_addr = 5'(i); dbg_addr = 5'(i);
            expect_val($sformatf("reset_rs_%0d", i), SEL_RS, 32'h0);
            expect_val($sformatf("reset_rt_%0d", i), SEL_RT, 32'h0);
            expect_val($sformatf("reset_dbg_%0d", i), SEL_DBG, 32'h0);
            step();
        end
        expect_val("reset_cnt", SEL_CNT, 32'd0);
        expect_val("reset_sat_cnt", SEL_SCNT, 32'd0);
        step();

        // 2: ALU write to r5 with same-cycle bypass
        regWrite_WB = 1'b1; memToReg_WB = 1'b0; aluRes_WB = 32'hDEADBEEF;
        writeReg_WB = 5'd5; rs_addr = 5'd5; rt_addr = 5'd0; dbg_addr = 5'd5;
        expect_val("t2_bypass_rs", SEL_RS, 32'hDEADBEEF);
        expect_val("t2_wbdata", SEL_WB, 32'hDEADBEEF);
        expect_val("t2_dbg_not_bypassed", SEL_DBG, 32'h0);
        expect_val("t2_nobypass_rs_old", SEL_NRS, 32'h0);
        step();
        regWrite_WB = 1'b0;
        expect_val("t2_dbg_after", SEL_DBG, 32'hDEADBEEF);
        expect_val("t2_rs_after", SEL_RS, 32'hDEADBEEF);
        expect_val("t2_cnt", SEL_CNT, 32'd1);
        step();

        // 3: load write to r31, both read ports on the target
        regWrite_WB = 1'b1; memToReg_WB = 1'b1; readData_WB = 32'h12345678;
        aluRes_WB = 32'hFFFF0000; writeReg_WB = 5'd31; rs_addr = 5'd31; rt_addr = 5'd31;
        expect_val("t3_wbdata", SEL_WB, 32'h12345678);
        expect_val("t3_bypass_rs", SEL_RS, 32'h12345678);
        expect_val("t3_bypass_rt", SEL_RT, 32'h12345678);
        step();
        regWrite_WB = 1'b0; memToReg_WB = 1'b0; dbg_addr = 5'd31;
        expect_val("t3_dbg_after", SEL_DBG, 32'h12345678);
        expect_val("t3_wbdata_follows", SEL_WB, 32'hFFFF0000);
        expect_val("t3_cnt", SEL_CNT, 32'd2);
        step();

        // 4: write to r0 is dropped and not counted
        regWrite_WB = 1'b1; memToReg_WB = 1'b0; aluRes_WB = 32'hFFFFFFFF;
        writeReg_WB = 5'd0; rs_addr = 5'd0; rt_addr = 5'd0; dbg_addr = 5'd0;
        expect_val("t4_rs_same", SEL_RS, 32'h0);
        expect_val("t4_rt_same", SEL_RT, 32'h0);
        expect_val("t4_dbg_same", SEL_DBG, 32'h0);
        expect_val("t4_wbdata", SEL_WB, 32'hFFFFFFFF);
        step();
        regWrite_WB = 1'b0;
        expect_val("t4_rs_after", SEL_RS, 32'h0);
        expect_val("t4_rt_after", SEL_RT, 32'h0);
        expect_val("t4_dbg_after", SEL_DBG, 32'h0);
        expect_val("t4_cnt", SEL_CNT, 32'd2);
        step();

        // 5: reset together with a write loses the write
        regWrite_WB = 1'b1; aluRes_WB = 32'h000000A5; writeReg_WB = 5'd7;
        step();
        rst = 1'b1; aluRes_WB = 32'h00000055; rs_addr = 5'd7; dbg_addr = 5'd7;
        expect_val("t5_rs_no_bypass_in_reset", SEL_RS, 32'h000000A5);
        expect_val("t5_dbg_in_reset", SEL_DBG, 32'h000000A5);
        expect_val("t5_cnt_in_reset", SEL_CNT, 32'd3);
        step();
        rst = 1'b0; regWrite_WB = 1'b0;
        expect_val("t5_rs_after", SEL_RS, 32'h0);
        expect_val("t5_dbg_after", SEL_DBG, 32'h0);
        expect_val("t5_cnt_after", SEL_CNT, 32'd0);
        expect_val("t5_sat_cnt_after", SEL_SCNT, 32'd0);
        step();

        // 6a: nine writes saturate a 3-bit counter at 7
        rs_addr = 5'd0; rt_addr = 5'd0;
        for (int i = 1; i <= 9; i++) begin
            regWrite_WB = 1'b1; aluRes_WB = 32'h100 + 32'(i); writeReg_WB = 5'(i);
            step();
        end
        regWrite_WB = 1'b0; dbg_addr = 5'd9;
        expect_val("t6_sat_cnt", SEL_SCNT, 32'd7);
        expect_val("t6_cnt", SEL_CNT, 32'd9);
        expect_val("t6_dbg_r9", SEL_DBG, 32'h109);
        step();

        // 6b: without bypass the new value appears one cycle later
        regWrite_WB = 1'b1; aluRes_WB = 32'hCAFEF00D; writeReg_WB = 5'd3; rs_addr = 5'd3;
        expect_val("t6_nobypass_old", SEL_NRS, 32'h103);
        expect_val("t6_bypass_new", SEL_RS, 32'hCAFEF00D);
        step();
        regWrite_WB = 1'b0;
        expect_val("t6_nobypass_new", SEL_NRS, 32'hCAFEF00D);
        step();

        step();
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
